cache_write_buffer: RTL and testbench

//  Parametrised single-clock write buffer between the cache write-back path and main memory.

---
 rtl/cache_write_buffer_pkg.sv | 23 ++
 rtl/cache_write_buffer_if.sv | 42 ++++
 rtl/cache_write_buffer_wb_byte_merge.sv | 28 ++
 rtl/cache_write_buffer.sv | 166 ++++++++++++++++
 tb/tb_cache_write_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_write_buffer_pkg.sv
// Shared definitions for the cache write buffer slice.
// Provides width helpers used by the buffer, its bus interface and the byte-merge unit,
// so the cache controller and memory arbiter can size their side of the port the same way.
package cache_write_buffer_pkg;

  localparam int unsigned BYTE_W = 8;

  // One strobe bit per data byte.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / BYTE_W;
  endfunction

  // Circular-array pointer width.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter must hold DEPTH itself, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cache_write_buffer_if.sv
// Bus bundle for the cache write buffer.
//   in_*      : write request from the cache (valid/ready)
//   out_*     : head entry offered to main memory (valid/ready)
//   lookup_*  : combinational read-hazard query
// Modports: master = cache/memory side driving requests, slave = the write buffer.
interface cache_write_buffer_if import cache_write_buffer_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic [STRB_WIDTH-1:0] in_strb;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic [STRB_WIDTH-1:0] out_strb;

  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  lookup_hit;
  logic [DATA_WIDTH-1:0] lookup_data;
  logic [STRB_WIDTH-1:0] lookup_strb;

  modport master (
    output in_valid, in_addr, in_data, in_strb, out_ready, lookup_addr,
    input  in_ready, out_valid, out_addr, out_data, out_strb,
    input  lookup_hit, lookup_data, lookup_strb
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_strb, out_ready, lookup_addr,
    output in_ready, out_valid, out_addr, out_data, out_strb,
    output lookup_hit, lookup_data, lookup_strb
  );

endinterface

// File: rtl/cache_write_buffer_wb_byte_merge.sv
// Byte-granular overlay: each byte of new_data whose strobe is set replaces the
// corresponding byte of old_data; strobes are ORed.
//   old_data/old_strb : existing bytes and their enables
//   new_data/new_strb : overriding bytes and their enables
//   data/strb         : merged result
module cache_write_buffer_wb_byte_merge import cache_write_buffer_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]             old_data,
  input  logic [strb_width(DATA_WIDTH)-1:0] old_strb,
  input  logic [DATA_WIDTH-1:0]             new_data,
  input  logic [strb_width(DATA_WIDTH)-1:0] new_strb,
  output logic [DATA_WIDTH-1:0]             data,
  output logic [strb_width(DATA_WIDTH)-1:0] strb
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

  always_comb begin
    data = old_data;
    for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
      if (new_strb[i]) data[BYTE_W*i +: BYTE_W] = new_data[BYTE_W*i +: BYTE_W];
    end
  end

  assign strb = old_strb | new_strb;

endmodule

// File: rtl/cache_write_buffer.sv
// In-order write buffer between the cache write-back path and main memory.
// Entries (addr, data, strb) drain first-word-fall-through from the head; a write to an
// address already queued in a non-head entry is coalesced in place. A combinational lookup
// port returns the pending bytes for an address so read misses see buffered data.
//   clk, rst          : single clock, synchronous active-high reset
//   bus (slave)       : in_* write port, out_* memory port, lookup_* hazard query
//   count             : valid entries, 0..DEPTH
//   full/empty/almost_full : flags derived from the registered count
module cache_write_buffer import cache_write_buffer_pkg::*; #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ALMOST_FULL_TH = 6,
  parameter bit          MERGE_EN       = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  cache_write_buffer_if.slave           bus,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full
);

  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);
  localparam int unsigned PTR_W      = ptr_width(DEPTH);
  localparam int unsigned CNT_W      = cnt_width(DEPTH);

  // Storage is not reset; valid_q alone qualifies it.
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [STRB_WIDTH-1:0] strb_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  merge_hit;
  logic [PTR_W-1:0]      merge_idx;
  logic [DATA_WIDTH-1:0] merge_data;
  logic [STRB_WIDTH-1:0] merge_strb;
  logic                  push, alloc, do_merge, pop;

  logic                  head_match, young_hit;
  logic [PTR_W-1:0]      young_idx, scan_idx;
  logic [DATA_WIDTH-1:0] head_lk_data;
  logic [STRB_WIDTH-1:0] head_lk_strb, head_sel_strb, young_sel_strb;

  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(ALMOST_FULL_TH));

  // Merge candidate: the head is excluded because it may leave this very cycle.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (MERGE_EN && valid_q[i] && (PTR_W'(i) != head_q) && (addr_q[i] == bus.in_addr)) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end

  assign bus.in_ready = !full || merge_hit;
  assign push         = bus.in_valid && bus.in_ready;
  assign alloc        = push && !merge_hit;
  assign do_merge     = push && merge_hit;

  assign bus.out_valid = !empty;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_addr  = bus.out_valid ? addr_q[head_q] : '0;
  assign bus.out_data  = bus.out_valid ? data_q[head_q] : '0;
  assign bus.out_strb  = bus.out_valid ? strb_q[head_q] : '0;

  cache_write_buffer_wb_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge_inplace (
    .old_data (data_q[merge_idx]),
    .old_strb (strb_q[merge_idx]),
    .new_data (bus.in_data),
    .new_strb (bus.in_strb),
    .data     (merge_data),
    .strb     (merge_strb)
  );

  always_comb begin
    count_d = count_q;
    if (alloc && !pop)      count_d = count_q + CNT_W'(1);
    else if (!alloc && pop) count_d = count_q - CNT_W'(1);
    valid_d = valid_q;
    if (pop)   valid_d[head_q] = 1'b0;
    if (alloc) valid_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (alloc) tail_q <= tail_q + PTR_W'(1);
      if (pop)   head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Merge index is never the head, so an in-place update cannot land in a popped entry.
  always_ff @(posedge clk) begin
    if (!rst && alloc) begin
      addr_q[tail_q] <= bus.in_addr;
      data_q[tail_q] <= bus.in_data;
      strb_q[tail_q] <= bus.in_strb;
    end
    if (!rst && do_merge) begin
      data_q[merge_idx] <= merge_data;
      strb_q[merge_idx] <= merge_strb;
    end
  end

  // Lookup: head match plus the youngest non-head match, overlaid oldest-first.
  // Bytes not covered by a matching strobe read as zero.
  always_comb begin
    head_match = valid_q[head_q] && (addr_q[head_q] == bus.lookup_addr);
    young_hit  = 1'b0;
    young_idx  = '0;
    scan_idx   = '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      scan_idx = head_q + PTR_W'(k);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == bus.lookup_addr)) begin
        young_hit = 1'b1;
        young_idx = scan_idx;
      end
    end
  end

  assign head_sel_strb  = head_match ? strb_q[head_q]    : '0;
  assign young_sel_strb = young_hit  ? strb_q[young_idx] : '0;

  cache_write_buffer_wb_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lookup_head (
    .old_data ('0),
    .old_strb ('0),
    .new_data (data_q[head_q]),
    .new_strb (head_sel_strb),
    .data     (head_lk_data),
    .strb     (head_lk_strb)
  );

  cache_write_buffer_wb_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lookup_young (
    .old_data (head_lk_data),
    .old_strb (head_lk_strb),
    .new_data (data_q[young_idx]),
    .new_strb (young_sel_strb),
    .data     (bus.lookup_data),
    .strb     (bus.lookup_strb)
  );

  assign bus.lookup_hit = head_match || young_hit;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Bench for cache_write_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cache_write_buffer;

  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count;
  logic       full, empty, almost_full;

  cache_write_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_write_buffer #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .DEPTH          (DEPTH),
    .ALMOST_FULL_TH (6),
    .MERGE_EN       (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  ent_t q[$];
  bit   started  = 1'b0;
  bit   last_acc = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Index of a queued non-head entry with this address, or -1.
  function automatic int m_merge_idx(input logic [31:0] a);
    for (int i = 1; i < q.size(); i++) if (q[i].addr == a) return i;
    return -1;
  endfunction

  task automatic m_lookup(input logic [31:0] a, output bit hit, output logic [31:0] d,
                          output logic [3:0] s);
    hit = 1'b0; d = '0; s = '0;
    foreach (q[i]) begin
      if (q[i].addr == a) begin
        hit = 1'b1;
        for (int b = 0; b < 4; b++) if (q[i].strb[b]) d[8*b +: 8] = q[i].data[8*b +: 8];
        s = s | q[i].strb;
      end
    end
  endtask

  // Reference model update on each clock edge.
  always @(posedge clk) begin
    int mj;
    bit rdy, acc, pp;
    if (rst) begin
      q.delete();
      started  = 1'b1;
      last_acc = 1'b0;
    end else begin
      mj  = m_merge_idx(bus.in_addr);
      rdy = (q.size() < DEPTH) || (mj >= 0);
      acc = bus.in_valid && rdy;
      pp  = (q.size() > 0) && bus.out_ready;
      if (acc) begin
        if (mj >= 0) begin
          for (int b = 0; b < 4; b++)
            if (bus.in_strb[b]) q[mj].data[8*b +: 8] = bus.in_data[8*b +: 8];
          q[mj].strb = q[mj].strb | bus.in_strb;
        end else begin
          q.push_back('{addr: bus.in_addr, data: bus.in_data, strb: bus.in_strb});
        end
      end
      if (pp) void'(q.pop_front());
      last_acc = acc;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit          e_hit;
    logic [31:0] e_ld;
    logic [3:0]  e_ls;
    bit          e_ne;
    if (started) begin
      e_ne = q.size() > 0;
      m_lookup(bus.lookup_addr, e_hit, e_ld, e_ls);
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == DEPTH);
      chk("almost_full", almost_full, q.size() >= 6);
      chk("in_ready", bus.in_ready,
          (q.size() < DEPTH) || (m_merge_idx(bus.in_addr) >= 0));
      chk("out_valid", bus.out_valid, e_ne);
      chk("out_addr", bus.out_addr, e_ne ? q[0].addr : 32'h0);
      chk("out_data", bus.out_data, e_ne ? q[0].data : 32'h0);
      chk("out_strb", bus.out_strb, e_ne ? q[0].strb : 4'h0);
      chk("lookup_hit", bus.lookup_hit, e_hit);
      chk("lookup_data", bus.lookup_data, e_ld);
      chk("lookup_strb", bus.lookup_strb, e_ls);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_strb  = s;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (q.size() > 0 && n < 64) begin
      cyc();
      n++;
    end
    bus.out_ready = 1'b0;
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cycles;
    bus.in_valid    = 1'b0;
    bus.in_addr     = '0;
    bus.in_data     = '0;
    bus.in_strb     = '0;
    bus.out_ready   = 1'b0;
    bus.lookup_addr = '0;

    // 1: reset, three writes, lookup
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rst_count", count, 0);
    chk("t1_rst_empty", empty, 1);
    chk("t1_rst_in_ready", bus.in_ready, 1);
    chk("t1_rst_out_valid", bus.out_valid, 0);
    wr(32'h100, 32'hD0000100, 4'hF);
    wr(32'h104, 32'hD0000104, 4'hF);
    wr(32'h108, 32'hD0000108, 4'hF);
    bus.lookup_addr = 32'h104;
    @(negedge clk);
    chk("t1_count", count, 3);
    chk("t1_out_addr", bus.out_addr, 32'h100);
    chk("t1_lookup_hit", bus.lookup_hit, 1);
    chk("t1_lookup_data", bus.lookup_data, 32'hD0000104);

    // 2: fill, almost_full boundary, full with push+pop refused
    wr(32'h10C, 32'h1, 4'hF);
    wr(32'h110, 32'h2, 4'hF);
    @(negedge clk);
    chk("t2_af_at5", almost_full, 0);
    wr(32'h114, 32'h3, 4'hF);
    @(negedge clk);
    chk("t2_af_at6", almost_full, 1);
    wr(32'h118, 32'h4, 4'hF);
    wr(32'h11C, 32'h5, 4'hF);
    bus.in_valid  = 1'b1;
    bus.in_addr   = 32'h500;
    bus.in_data   = 32'h55;
    bus.in_strb   = 4'hF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t2_full", full, 1);
    chk("t2_in_ready", bus.in_ready, 0);
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t2_count_after", count, 7);
    drain();

    // 3: same address at head allocates; non-head merges
    wr(32'h200, 32'h11223344, 4'hF);
    wr(32'h204, 32'h55667788, 4'hF);
    wr(32'h200, 32'hAAAABBBB, 4'h3);
    bus.lookup_addr = 32'h200;
    @(negedge clk);
    chk("t3_alloc_count", count, 3);
    chk("t3_lookup_data", bus.lookup_data, 32'h1122BBBB);
    chk("t3_lookup_strb", bus.lookup_strb, 4'hF);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    wr(32'h200, 32'hCCDD0000, 4'hC);
    @(negedge clk);
    chk("t3_merge_count", count, 2);
    chk("t3_merge_data", bus.lookup_data, 32'hCCDDBBBB);
    drain();

    // 4: merge into entry that becomes head on the same cycle; zero-strobe write
    wr(32'h2F0, 32'h0F0F0F0F, 4'hF);
    wr(32'h300, 32'h12345678, 4'h3);
    bus.out_ready = 1'b1;
    wr(32'h300, 32'h00CC0000, 4'h4);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t4_count", count, 1);
    chk("t4_out_addr", bus.out_addr, 32'h300);
    chk("t4_out_data", bus.out_data, 32'h12CC5678);
    chk("t4_out_strb", bus.out_strb, 4'h7);
    wr(32'h300, 32'hFFFFFFFF, 4'h0);
    bus.lookup_addr = 32'h300;
    @(negedge clk);
    chk("t4_zero_strb_count", count, 2);
    chk("t4_lookup_data", bus.lookup_data, 32'h00CC5678);
    chk("t4_lookup_strb", bus.lookup_strb, 4'h7);
    drain();

    // 5: streaming across pointer wrap with random back-pressure
    k = 0;
    cycles = 0;
    while (k < 3 * DEPTH && cycles < 1000) begin
      bus.in_valid    = 1'b1;
      bus.in_addr     = 32'h1000 + 32'(k) * 4;
      bus.in_data     = $urandom;
      bus.in_strb     = 4'hF;
      bus.out_ready   = 1'($urandom_range(0, 1));
      bus.lookup_addr = 32'h1000 + 32'($urandom_range(0, 3 * DEPTH)) * 4;
      cyc();
      if (last_acc) k++;
      cycles++;
    end
    bus.in_valid = 1'b0;
    chk("t5_progress", k, 3 * DEPTH);
    drain();

    // 6: reset mid-stream dominates push and pop
    for (int i = 0; i < 5; i++) wr(32'h700 + 32'(i) * 4, 32'hE0 + 32'(i), 4'hF);
    bus.lookup_addr = 32'h700;
    @(negedge clk);
    chk("t6_pre_count", count, 5);
    bus.in_valid  = 1'b1;
    bus.in_addr   = 32'h720;
    bus.in_data   = 32'h77;
    bus.in_strb   = 4'hF;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    cyc();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t6_count", count, 0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_lookup_hit", bus.lookup_hit, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
